// File: rtl/count_run_ctrl_pkg.sv
// Shared types and constants for the counter run-control stage.
package count_run_ctrl_pkg;

  localparam int COUNT_W = 4;
  localparam logic [COUNT_W-1:0] CNT_TERM = 4'hF;

  localparam int NUM_BTN = 2;
  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/count_run_ctrl_if.sv
// Button inputs, counter feedback and control outputs of the run-control stage.
interface count_run_ctrl_if;
  import count_run_ctrl_pkg::*;

  logic               btn_start_stop;
  logic               btn_clear;
  logic [COUNT_W-1:0] count_in;
  logic               cnt_en;
  logic               cnt_clr;
  logic               running;
  logic [1:0]         state;

  modport master (
    input  btn_start_stop, btn_clear, count_in,
    output cnt_en, cnt_clr, running, state
  );

  modport slave (
    output btn_start_stop, btn_clear, count_in,
    input  cnt_en, cnt_clr, running, state
  );

endinterface

// File: rtl/count_run_ctrl_btn_debounce.sv
// 2-FF synchronizer, stable-sample debounce and one-cycle press pulse for one raw button.
module btn_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          s1, s2;
  logic          level, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_q <= level;
      press   <= level & ~level_q;
      // any sample agreeing with the level restarts the stability count
      if (s2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/count_run_ctrl.sv
// Run/pause/done control for the 4-bit counter: debounced buttons in, prescaled
// count-enable and clear pulses out.
module count_run_ctrl
  import count_run_ctrl_pkg::*;
#(
  parameter int PRESCALE = 10,  // >= 2
  parameter int DEBOUNCE = 4,   // >= 1
  parameter int ONESHOT  = 0
) (
  input  logic             clk,
  input  logic             resetn,
  count_run_ctrl_if.master bus
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [NUM_BTN-1:0] raw, press;
  logic               ss, clr, term;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          en_q, en_d, clr_q, clr_d, run_q;

  assign raw[BTN_SS]  = bus.btn_start_stop;
  assign raw[BTN_CLR] = bus.btn_clear;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk    (clk),
      .resetn (resetn),
      .raw    (raw[i]),
      .press  (press[i])
    );
  end

  assign ss   = press[BTN_SS];
  assign clr  = press[BTN_CLR];
  assign term = (ONESHOT != 0) && (bus.count_in == CNT_TERM);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    en_d    = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr)     clr_d   = 1'b1;
        else if (ss) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          en_d  = 1'b1;
        end else begin
          pre_d = pre_q + PW'(1);
        end
        // clear beats terminal stop, which beats start/stop; both kill a due tick
        if (clr) begin
          clr_d = 1'b1;
          en_d  = 1'b0;
        end else if (term) begin
          state_d = ST_DONE;
          en_d    = 1'b0;
        end else if (ss) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (clr) begin
          clr_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (ss) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (clr) begin
          clr_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // a fresh run or any clear starts the prescaler from zero; resume keeps it
    if (clr || (state_q == ST_IDLE && state_d == ST_RUN)) pre_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      run_q   <= (state_d == ST_RUN);
    end
  end

  assign bus.cnt_en  = en_q;
  assign bus.cnt_clr = clr_q;
  assign bus.running = run_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// Directed bench for count_run_ctrl with PRESCALE=4, DEBOUNCE=4, ONESHOT=1.
module tb_count_run_ctrl;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  count_run_ctrl_if bus ();

  count_run_ctrl #(.PRESCALE(4), .DEBOUNCE(4), .ONESHOT(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [15:0] en_h, clr_h;
    logic        st_bad;
    resetn = 1'b0;
    bus.btn_start_stop = 1'b1;
    bus.btn_clear = 1'b1;
    bus.count_in = 4'h0;
    step(2);
    checks++;
    if ({bus.cnt_en, bus.cnt_clr, bus.running} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %b required 000", {bus.cnt_en, bus.cnt_clr, bus.running});
    end
    checks++;
    if (bus.state !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got %b required 00", bus.state);
    end
    resetn = 1'b1;
    en_h = '0; clr_h = '0; st_bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      en_h[k] = bus.cnt_en;
      clr_h[k] = bus.cnt_clr;
      if (bus.state !== 2'b00) st_bad = 1'b1;
    end
    checks++;
    if (clr_h !== 16'h0080) begin
      errors++;
      $display("FAIL reset_held_clr: got %h required 0080", clr_h);
    end
    checks++;
    if (en_h !== 16'h0000 || st_bad !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_ss: en %h stbad %b required 0000 0", en_h, st_bad);
    end
    bus.btn_start_stop = 1'b0;
    bus.btn_clear = 1'b0;
    step(10);
  endtask

  task automatic test_glitch();
    logic [19:0] en_h;
    logic        st_bad;
    bus.btn_start_stop = 1'b1;
    step(3);
    bus.btn_start_stop = 1'b0;
    en_h = '0; st_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      en_h[k] = bus.cnt_en;
      if (bus.state !== 2'b00 || bus.running !== 1'b0) st_bad = 1'b1;
    end
    checks++;
    if (en_h !== 20'h0 || st_bad !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: en %h stbad %b required 00000 0", en_h, st_bad);
    end
  endtask

  task automatic test_start();
    logic [31:0] en_h;
    logic [1:0]  st_h [0:31];
    logic        run7;
    en_h = '0; run7 = 1'b0;
    bus.btn_start_stop = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step(1);
      if (k == 9) bus.btn_start_stop = 1'b0;
      en_h[k] = bus.cnt_en;
      st_h[k] = bus.state;
      if (k == 7) run7 = bus.running;
    end
    checks++;
    if (st_h[6] !== 2'b00 || st_h[7] !== 2'b01) begin
      errors++;
      $display("FAIL start_latency: state@6 %b state@7 %b required 00 01", st_h[6], st_h[7]);
    end
    checks++;
    if (run7 !== 1'b1) begin
      errors++;
      $display("FAIL start_running: got %b required 1", run7);
    end
    checks++;
    if (en_h !== 32'h0088_8800) begin
      errors++;
      $display("FAIL start_ticks: got %h required 00888800", en_h);
    end
  endtask

  task automatic test_pause_resume();
    logic [15:0] en_h;
    logic [1:0]  st_h [0:15];
    logic        found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1);
      if (bus.cnt_en === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL pause_wait_tick: got no cnt_en required one within 8 cycles");
    end
    step(2);
    en_h = '0;
    bus.btn_start_stop = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (k == 9) bus.btn_start_stop = 1'b0;
      en_h[k] = bus.cnt_en;
      st_h[k] = bus.state;
    end
    checks++;
    if (st_h[6] !== 2'b01 || st_h[7] !== 2'b10 || st_h[15] !== 2'b10) begin
      errors++;
      $display("FAIL pause_state: %b %b %b required 01 10 10", st_h[6], st_h[7], st_h[15]);
    end
    checks++;
    if (en_h !== 16'h0022) begin
      errors++;
      $display("FAIL pause_ticks: got %h required 0022", en_h);
    end
    step(2);
    en_h = '0;
    bus.btn_start_stop = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (k == 9) bus.btn_start_stop = 1'b0;
      en_h[k] = bus.cnt_en;
      st_h[k] = bus.state;
    end
    checks++;
    if (st_h[6] !== 2'b10 || st_h[7] !== 2'b01) begin
      errors++;
      $display("FAIL resume_state: %b %b required 10 01", st_h[6], st_h[7]);
    end
    checks++;
    if (en_h !== 16'h2200) begin
      errors++;
      $display("FAIL resume_ticks: got %h required 2200", en_h);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] en_h, clr_h;
    logic        st_bad, found;
    step(2);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1);
      if (bus.cnt_en === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL simul_wait_tick: got no cnt_en required one within 8 cycles");
    end
    en_h = '0; clr_h = '0; st_bad = 1'b0;
    bus.btn_start_stop = 1'b1;
    bus.btn_clear = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (k == 9) begin
        bus.btn_start_stop = 1'b0;
        bus.btn_clear = 1'b0;
      end
      en_h[k] = bus.cnt_en;
      clr_h[k] = bus.cnt_clr;
      if (bus.state !== 2'b01) st_bad = 1'b1;
    end
    checks++;
    if (clr_h !== 16'h0080) begin
      errors++;
      $display("FAIL simul_clr: got %h required 0080", clr_h);
    end
    checks++;
    if (en_h !== 16'h8808) begin
      errors++;
      $display("FAIL simul_ticks: got %h required 8808", en_h);
    end
    checks++;
    if (st_bad !== 1'b0) begin
      errors++;
      $display("FAIL simul_state: left RUN, got 1 required 0");
    end
  endtask

  task automatic test_oneshot();
    logic [15:0] en_h, clr_h;
    logic [1:0]  st_h [0:15];
    logic        st_bad, found;
    step(2);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1);
      if (bus.cnt_en === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL oneshot_wait_tick: got no cnt_en required one within 8 cycles");
    end
    step(3);
    bus.count_in = 4'hF;
    step(1);
    checks++;
    if ({bus.state, bus.running, bus.cnt_en} !== 4'b1100) begin
      errors++;
      $display("FAIL oneshot_done: state/run/en %b required 1100", {bus.state, bus.running, bus.cnt_en});
    end
    en_h = '0; clr_h = '0; st_bad = 1'b0;
    bus.btn_start_stop = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (k == 9) bus.btn_start_stop = 1'b0;
      en_h[k] = bus.cnt_en;
      clr_h[k] = bus.cnt_clr;
      if (bus.state !== 2'b11) st_bad = 1'b1;
    end
    checks++;
    if (en_h !== 16'h0 || clr_h !== 16'h0 || st_bad !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_ss_ignored: en %h clr %h stbad %b required 0000 0000 0", en_h, clr_h, st_bad);
    end
    step(2);
    en_h = '0; clr_h = '0;
    bus.btn_clear = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (k == 9) bus.btn_clear = 1'b0;
      en_h[k] = bus.cnt_en;
      clr_h[k] = bus.cnt_clr;
      st_h[k] = bus.state;
    end
    bus.count_in = 4'h0;
    checks++;
    if (clr_h !== 16'h0080 || en_h !== 16'h0) begin
      errors++;
      $display("FAIL oneshot_clear: clr %h en %h required 0080 0000", clr_h, en_h);
    end
    checks++;
    if (st_h[6] !== 2'b11 || st_h[7] !== 2'b00 || st_h[15] !== 2'b00) begin
      errors++;
      $display("FAIL oneshot_to_idle: %b %b %b required 11 00 00", st_h[6], st_h[7], st_h[15]);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_start();
    test_pause_resume();
    test_simultaneous();
    test_oneshot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_run_ctrl.md
Name: count_run_ctrl

Overview:
- Control stage directly upstream of the 4-bit free-running counter.
- Turns two raw push-buttons (start/stop, clear) into clean control for the counter: a rate-divided count-enable pulse and a synchronous clear pulse.
- Run/pause/done FSM driven by debounced press events; monitors the counter value for an optional one-shot stop at terminal count.
- Top level gates the counter as: counter.resetn = resetn & ~cnt_clr, counter advances only on cnt_en.

Parameters:
- PRESCALE, 10, clk cycles per cnt_en pulse while running; must be >= 2.
- DEBOUNCE, 4, consecutive stable synchronized samples needed to change a debounced level; must be >= 1.
- ONESHOT, 0, 1 = stop at count_in == 4'hF and enter DONE; 0 = run indefinitely.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- btn_start_stop  in  1  raw asynchronous button, active high.
- btn_clear  in  1  raw asynchronous button, active high.
- count_in  in  4  current counter value, fed back from the counter.
- cnt_en  out  1  one-cycle counter advance pulse, registered.
- cnt_clr  out  1  one-cycle counter clear pulse, registered.
- running  out  1  high while in RUN.
- state  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Reset (resetn low at a clk edge):
  - cnt_en, cnt_clr, running = 0; state = IDLE.
  - Prescaler = 0.
  - Synchronizer FFs, debounce counters and debounced levels = 0.
  - Applies mid-operation and overrides everything.
  - A button held through reset produces one press after the normal debounce latency.
- Debounce, per button:
  - 2-FF synchronizer.
  - Counter increments while synced value != debounced level; clears to 0 when they are equal.
  - Level toggles at the edge where the counter reaches DEBOUNCE; counter then clears.
  - Press pulse is registered on the rising edge of the level and lasts exactly 1 cycle.
  - Latency: raw first sampled high at edge E0 -> level high after E(DEBOUNCE+1) -> press high during the cycle after E(DEBOUNCE+2).
  - Pulses shorter than DEBOUNCE synced cycles are ignored.
  - Release events produce no pulse.
- Prescaler:
  - Width clog2(PRESCALE). Counts only in RUN.
  - At value PRESCALE-1 it wraps to 0 and cnt_en is asserted in the following cycle.
  - First cnt_en comes PRESCALE edges after entering RUN from IDLE.
  - Holds its value in PAUSE. Forced to 0 on IDLE->RUN and on any clear press.
- FSM (ss = start/stop press, clr = clear press):
  - IDLE: ss -> RUN. clr -> cnt_clr pulse, stay IDLE.
  - RUN: ss -> PAUSE. clr -> cnt_clr pulse, prescaler 0, stay RUN.
    - If ONESHOT=1 and count_in == 4'hF: -> DONE, no further cnt_en; a tick due in that cycle is suppressed.
  - PAUSE: ss -> RUN, prescaler resumes from its held value. clr -> cnt_clr pulse, prescaler 0, -> IDLE.
  - DONE: ss ignored. clr -> cnt_clr pulse, -> IDLE.
- Simultaneous events:
  - ss and clr in the same cycle: clr action wins, ss discarded.
  - cnt_en and cnt_clr are never high together; clr suppresses a coincident tick.
- Output registration: running and state are registered and reflect the new state one edge after the triggering press.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE), COUNT_W = 4, terminal value 4'hF.
- Sub-module btn_debounce (synchronizer + debounce + press pulse), instantiated twice.

Test Plan:
- Reset: resetn low 2 cycles with both buttons high -> all outputs 0, state 00. Buttons still held after release -> exactly one ss press and one clr press; clr wins, state stays 00, one cnt_clr.
- Start, with PRESCALE=4 and DEBOUNCE=4: btn_start_stop high 10 cycles from E0 -> press during cycle after E6; state 01 and running 1 after E7; cnt_en 1-cycle pulses after E11, E15, E19...
- Glitch reject: btn_start_stop high 3 cycles, then low -> no press; state stays 00, no cnt_en.
- Pause/resume: press ss 2 cycles after a cnt_en -> state 10, prescaler held at its current value. Press ss again -> state 01; next cnt_en arrives so that total RUN cycles between pulses equals 4.
- Simultaneous press in RUN: both buttons rise together -> exactly one cnt_clr, state stays 01, no cnt_en in that cycle; next cnt_en 4 edges later.
- One-shot, ONESHOT=1: in RUN, drive count_in = 4'hF -> state 11, running 0, no further cnt_en. ss press ignored. clr press -> one cnt_clr, state 00.
